// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request, RAM and response signals of the load/store control stage
// slave modport is the lsu_ctrl side; master is the pipeline/RAM environment side.
interface lsu_ctrl_if #(
   parameter int MEM_AW = 5,
   parameter int STAT_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              mem_read_en;
   logic              mem_write_en;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]        mem_byte_en;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [STAT_W-1:0] stat_loads;
   logic [STAT_W-1:0] stat_stores;
   logic [STAT_W-1:0] stat_errs;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, mem_read_en, mem_write_en, mem_addr, mem_byte_en, mem_wdata,
      output resp_valid, resp_rdata, resp_err, stat_loads, stat_stores, stat_errs
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, mem_read_en, mem_write_en, mem_addr, mem_byte_en, mem_wdata,
      input  resp_valid, resp_rdata, resp_err, stat_loads, stat_stores, stat_errs
   );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store control stage with alignment/range checks
// Optional outcome counters are built only when LSU_STATS_EN is defined.
module lsu_ctrl #(
   parameter int MEM_AW = 5,
   parameter int STAT_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   lsu_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [MEM_AW+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              req_err;
   logic [31:0]       shifted;
   logic [31:0]       load_data;

   always_comb begin
      req_err = 1'b0;
      case (bus.req_funct3[1:0])
         2'b01:   if (bus.req_addr[0]) req_err = 1'b1;
         2'b10:   if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
         default: ;
      endcase
      if (bus.req_we) begin
         if (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11) req_err = 1'b1;
      end else if (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11) begin
         req_err = 1'b1;
      end
      if (|(bus.req_addr >> (MEM_AW + 2))) req_err = 1'b1;
   end

   // RAM word is already registered by the RAM, so lane select only shifts it down
   always_comb begin
      shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = shifted;
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = 32'd0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            we_d     = bus.req_we;
            funct3_d = bus.req_funct3;
            addr_d   = bus.req_addr[MEM_AW+1:0];
            wdata_d  = bus.req_wdata;
            rdata_d  = 32'd0;
            err_d    = req_err;
            state_d  = req_err ? RESP : ACCESS;
         end
         ACCESS:  state_d = we_q ? RESP : WAIT;
         WAIT: begin
            rdata_d = load_data;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Strobes come from state only so an async reset drops them immediately
   always_comb begin
      bus.mem_read_en  = 1'b0;
      bus.mem_write_en = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_byte_en  = 4'b0000;
      bus.mem_wdata    = 32'd0;
      if (state_q == ACCESS) begin
         bus.mem_addr     = addr_q[MEM_AW+1:2];
         bus.mem_read_en  = ~we_q;
         bus.mem_write_en = we_q;
         if (we_q) begin
            case (funct3_q[1:0])
               2'b00: begin
                  bus.mem_byte_en = 4'b0001 << addr_q[1:0];
                  bus.mem_wdata   = {4{wdata_q[7:0]}};
               end
               2'b01: begin
                  bus.mem_byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                  bus.mem_wdata   = {2{wdata_q[15:0]}};
               end
               default: begin
                  bus.mem_byte_en = 4'b1111;
                  bus.mem_wdata   = wdata_q;
               end
            endcase
         end
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

`ifdef LSU_STATS_EN
   logic [STAT_W-1:0] loads_q, loads_d, stores_q, stores_d, errs_q, errs_d;

   always_comb begin
      loads_d  = loads_q;
      stores_d = stores_q;
      errs_d   = errs_q;
      if (state_q == RESP) begin
         if (err_q) begin
            if (~&errs_q) errs_d = errs_q + 1'b1;
         end else if (we_q) begin
            if (~&stores_q) stores_d = stores_q + 1'b1;
         end else begin
            if (~&loads_q) loads_d = loads_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loads_q  <= '0;
         stores_q <= '0;
         errs_q   <= '0;
      end else begin
         loads_q  <= loads_d;
         stores_q <= stores_d;
         errs_q   <= errs_d;
      end
   end

   assign bus.stat_loads  = loads_q;
   assign bus.stat_stores = stores_q;
   assign bus.stat_errs   = errs_q;
`else
   assign bus.stat_loads  = {STAT_W{1'b0}};
   assign bus.stat_stores = {STAT_W{1'b0}};
   assign bus.stat_errs   = {STAT_W{1'b0}};
`endif
endmodule
